uart_tx_p5: RTL

Byte-serial UART transmitter (8N1) that drives `io_p5[0]` from the CPU I/O write path. It is the transmit counterpart of the `io_p4[0]` receive line, whose idle level is high. It buffers CPU writes in a small FIFO and serialises them at a fixed bit period, so software can issue bursts without polling per byte. It sits inside `top` between the CPU I/O port decode and the `io_p5` pin.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_p5.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and FSM state encoding
package uart_pkg;
   typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_e;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered flags/count and head visible without a read cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   logic [AW:0] count_n;
   assign dout = mem[rp];
   // gate requests by flags; next occupancy drives the registered flags
   always_comb begin
      do_push = push && !full;
      do_pop = pop && !empty;
      count_n = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end
   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         full <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count_n;
         full <= count_n == FULL_CNT;
         empty <= count_n == '0;
      end
   end
endmodule

// File: rtl/uart_tx_p5.sv
// uart_tx_p5: FIFO-buffered 8N1 UART transmitter with registered serial output
module uart_tx_p5 import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_in,
   input  logic                          rst,
   input  logic [7:0]                    wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
   uart_state_e state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_cnt, bit_n;
   logic [7:0] shift, shift_n, head;
   logic pop, push, full, empty, tx_n;
   logic [NW-1:0] count_n;
   assign wr_ready = !full;
   assign push = wr_valid && wr_ready;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk_in),
      .rst(rst),
      .push(push),
      .din(wr_data),
      .pop(pop),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   // next-state, baud/bit counters, shifter and the line level of the next cycle
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      bit_n = bit_cnt;
      shift_n = shift;
      pop = 1'b0;
      case (state)
         UART_IDLE: begin
            cnt_n = '0;
            if (!empty) begin
               state_n = UART_START;
               pop = 1'b1;
               shift_n = head;
            end
         end
         UART_START: if (cnt == LAST) begin
            state_n = UART_DATA;
            cnt_n = '0;
         end
         UART_DATA: if (cnt == LAST) begin
            cnt_n = '0;
            shift_n = shift >> 1;
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state_n = UART_STOP;
         end
         UART_STOP: if (cnt == LAST) begin
            cnt_n = '0;
            state_n = empty ? UART_IDLE : UART_START;
            pop = !empty;
            shift_n = empty ? shift : head;
         end
         default: state_n = UART_IDLE;
      endcase
      tx_n = state_n == UART_START ? 1'b0 : state_n == UART_DATA ? shift_n[0] : 1'b1;
      count_n = fifo_count + {{(NW-1){1'b0}}, push} - {{(NW-1){1'b0}}, pop};
   end
   // state register; tx and busy are registered from next-cycle values
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state <= UART_IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         shift <= '0;
         tx <= 1'b1;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_cnt <= bit_n;
         shift <= shift_n;
         tx <= tx_n;
         busy <= (state_n != UART_IDLE) || (count_n != '0);
      end
   end
endmodule
